// File: rtl/assertion_agg_if.sv
// Failure-aggregator bus: failure sources and stop handshake in,
// captured status out.
interface assertion_agg_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] fail_in;
  logic [NUM_CH-1:0] mask;
  logic              clear;
  logic              stop_ack;
  logic              FAILURE;
  logic [NUM_CH-1:0] sticky_vec;
  logic              first_valid;
  logic [ID_W-1:0]   first_id;
  logic [CNT_W-1:0]  fail_count;
  logic              stop_req;

  modport master (
    output fail_in, mask, clear, stop_ack,
    input  FAILURE, sticky_vec, first_valid,
    input  first_id, fail_count, stop_req
  );

  modport slave (
    input  fail_in, mask, clear, stop_ack,
    output FAILURE, sticky_vec, first_valid,
    output first_id, fail_count, stop_req
  );
endinterface

// File: rtl/assertion_agg.sv
// Sticky failure aggregator: latches per-channel failures, first id,
// saturating failure-cycle count and a stop-request handshake.
module assertion_agg #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int STOP_EN = 1
) (
  input logic             clk,
  input logic             rst,
  assertion_agg_if.slave  bus
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HALT
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] active;
  logic              any_active;
  logic [ID_W-1:0]   low_id;

  // downward scan so the lowest set index is the last one written
  always_comb begin
    active     = bus.fail_in & ~bus.mask;
    any_active = |active;
    low_id     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active[i]) low_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.FAILURE     <= 1'b0;
      bus.sticky_vec  <= '0;
      bus.first_valid <= 1'b0;
      bus.first_id    <= '0;
      bus.fail_count  <= '0;
    end else if (bus.clear) begin
      bus.FAILURE     <= 1'b0;
      bus.sticky_vec  <= '0;
      bus.first_valid <= 1'b0;
      bus.first_id    <= '0;
      bus.fail_count  <= '0;
    end else begin
      bus.FAILURE    <= |bus.sticky_vec;
      bus.sticky_vec <= bus.sticky_vec | active;
      if (!bus.first_valid && any_active) begin
        bus.first_valid <= 1'b1;
        bus.first_id    <= low_id;
      end
      if (any_active && (bus.fail_count != '1))
        bus.fail_count <= bus.fail_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.stop_req <= 1'b0;
    end else if (bus.clear) begin
      state        <= IDLE;
      bus.stop_req <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if ((STOP_EN != 0) && any_active) begin
            state        <= REQ;
            bus.stop_req <= 1'b1;
          end
        end
        REQ: begin
          if (bus.stop_ack) begin
            state        <= HALT;
            bus.stop_req <= 1'b0;
          end
        end
        HALT: begin
          bus.stop_req <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.stop_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_assertion_agg.sv
// Randomized bench for assertion_agg: three builds (default, 2-bit
// counter, stop disabled) share stimulus and one reference model.
module tb_assertion_agg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fail_in = '0;
  logic [3:0] mask = '0;
  logic       clear = 1'b0;
  logic       stop_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  int m_sticky, m_fail, m_fv, m_id, m_cnt, m_st;

  always #5 clk = ~clk;

  assertion_agg_if #(.NUM_CH(4), .CNT_W(16)) b0 ();
  assertion_agg_if #(.NUM_CH(4), .CNT_W(2))  b1 ();
  assertion_agg_if #(.NUM_CH(4), .CNT_W(16)) b2 ();

  assign b0.fail_in = fail_in;
  assign b0.mask = mask;
  assign b0.clear = clear;
  assign b0.stop_ack = stop_ack;
  assign b1.fail_in = fail_in;
  assign b1.mask = mask;
  assign b1.clear = clear;
  assign b1.stop_ack = stop_ack;
  assign b2.fail_in = fail_in;
  assign b2.mask = mask;
  assign b2.clear = clear;
  assign b2.stop_ack = stop_ack;

  assertion_agg #(.NUM_CH(4), .CNT_W(16), .STOP_EN(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  assertion_agg #(.NUM_CH(4), .CNT_W(2), .STOP_EN(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  assertion_agg #(.NUM_CH(4), .CNT_W(16), .STOP_EN(0)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_sticky = 0; m_fail = 0; m_fv = 0;
    m_id = 0; m_cnt = 0; m_st = 0;
  endfunction

  // one clock edge of the specified behaviour, integer arithmetic
  function automatic void m_step(int f, int m, int c, int a);
    int act;
    act = f & ~m & 15;
    if (c != 0) begin
      m_reset();
      return;
    end
    m_fail = (m_sticky != 0) ? 1 : 0;
    if (m_fv == 0 && act != 0) begin
      m_fv = 1;
      m_id = 0;
      while (((act >> m_id) & 1) == 0) m_id++;
    end
    m_sticky = m_sticky | act;
    if (act != 0 && m_cnt < 65535) m_cnt++;
    if (m_st == 0 && act != 0) m_st = 1;
    else if (m_st == 1 && a != 0) m_st = 2;
  endfunction

  task automatic check_all();
    int c2;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    chk("failure", 32'(b0.FAILURE), 32'(m_fail));
    chk("sticky", 32'(b0.sticky_vec), 32'(m_sticky));
    chk("fvalid", 32'(b0.first_valid), 32'(m_fv));
    chk("fid", 32'(b0.first_id), 32'(m_id));
    chk("count", 32'(b0.fail_count), 32'(m_cnt));
    chk("stopreq", 32'(b0.stop_req), (m_st == 1) ? 32'd1 : 32'd0);
    chk("count_w2", 32'(b1.fail_count), 32'(c2));
    chk("stopreq_w2", 32'(b1.stop_req), (m_st == 1) ? 32'd1 : 32'd0);
    chk("stopreq_nostop", 32'(b2.stop_req), 32'd0);
    chk("sticky_nostop", 32'(b2.sticky_vec), 32'(m_sticky));
    chk("fid_nostop", 32'(b2.first_id), 32'(m_id));
  endtask

  // inputs change on negedge, DUT samples on posedge, checked #1 later
  task automatic cyc(input logic [3:0] f, input logic [3:0] m,
                     input logic c, input logic a);
    fail_in = f; mask = m; clear = c; stop_ack = a;
    @(posedge clk);
    m_step(int'(f), int'(m), int'(c), int'(a));
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("arst_stopreq", 32'(b0.stop_req), 32'd0);
    chk("arst_failure", 32'(b0.FAILURE), 32'd0);
    chk("arst_sticky", 32'(b0.sticky_vec), 32'd0);
    chk("arst_count", 32'(b0.fail_count), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    @(negedge clk);
  endtask

  int hold_exp [6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    m_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    cyc(4'b0100, 4'b0000, 1'b0, 1'b0);
    chk("r37_sticky", 32'(b0.sticky_vec), 32'h4);
    chk("r37_id", 32'(b0.first_id), 32'd2);
    chk("r37_stop", 32'(b0.stop_req), 32'd1);
    chk("r37_fail0", 32'(b0.FAILURE), 32'd0);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("r37_fail1", 32'(b0.FAILURE), 32'd1);
    chk("r37_stillreq", 32'(b0.stop_req), 32'd1);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("r40_ack", 32'(b0.stop_req), 32'd0);
    cyc(4'b1000, 4'b0000, 1'b0, 1'b0);
    chk("r40_halt", 32'(b0.stop_req), 32'd0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("r40_clr_fail", 32'(b0.FAILURE), 32'd0);
    chk("r40_clr_cnt", 32'(b0.fail_count), 32'd0);

    cyc(4'b1010, 4'b0000, 1'b0, 1'b0);
    chk("r38_id", 32'(b0.first_id), 32'd1);
    cyc(4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("r38_id_keep", 32'(b0.first_id), 32'd1);
    chk("r38_sticky", 32'(b0.sticky_vec), 32'hb);
    cyc(4'b0000, 4'b1011, 1'b0, 1'b0);
    chk("r23_maskkeep", 32'(b0.sticky_vec), 32'hb);

    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0001, 4'b0000, 1'b0, 1'b0);
      chk("r39_sat", 32'(b1.fail_count), 32'(hold_exp[i]));
    end

    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    chk("r41_masked", 32'(b0.first_valid), 32'd0);
    chk("r41_nostop", 32'(b0.stop_req), 32'd0);
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0);
    chk("r41_clrwins", 32'(b0.sticky_vec), 32'd0);
    cyc(4'b0010, 4'b0000, 1'b0, 1'b0);
    chk("r41_next", 32'(b0.sticky_vec), 32'h2);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("r33_clr_ack", 32'(b0.stop_req), 32'd0);

    cyc(4'b0100, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    async_reset();

    for (int n = 0; n < 600; n++) begin
      logic [3:0] f, m;
      logic c, a;
      f = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      c = ($urandom_range(0, 24) == 0);
      a = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      else cyc(f, m, c, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/assertion_agg.md
ASSERTION_AGG -- requirements
Module: assertion_agg

Interface
REQ-001 Parameter NUM_CH, default 4, number of failure-source channels; legal range 1..32.
REQ-002 Parameter CNT_W, default 16, width of the failure-cycle counter; legal range 2..32.
REQ-003 Parameter STOP_EN, default 1; 1 enables the stop-request handshake, 0 disables it.
REQ-004 Derived ID_W = max(1, ceil(log2(NUM_CH))).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 fail_in  input  NUM_CH  per-channel failure level (e.g. stop, ucf, user assertions).
REQ-008 mask  input  NUM_CH  per-channel mask; 1 ignores that channel.
REQ-009 clear  input  1  synchronous single-cycle clear of all captured state.
REQ-010 stop_ack  input  1  emulator-control acknowledge of stop_req.
REQ-011 FAILURE  output  1  registered OR of sticky_vec.
REQ-012 sticky_vec  output  NUM_CH  latched per-channel failure flags.
REQ-013 first_valid  output  1  first_id holds a captured channel.
REQ-014 first_id  output  ID_W  index of first failing channel.
REQ-015 fail_count  output  CNT_W  number of cycles with at least one unmasked failure.
REQ-016 stop_req  output  1  request to halt emulation.

Function
REQ-017 active = fail_in & ~mask, evaluated every cycle; any_active = OR of active.
REQ-018 sticky_vec shall update to sticky_vec | active on each edge; bits never self-clear.
REQ-019 FAILURE shall equal OR of sticky_vec, i.e. assert one cycle after the first active edge sample.
REQ-020 When first_valid=0 and any_active=1, first_id shall load the lowest index set in active and first_valid shall set on the same edge.
REQ-021 While first_valid=1, first_id shall not change, even if other channels fail later.
REQ-022 fail_count shall increment by 1 on each edge with any_active=1, saturate at 2^CNT_W-1, never wrap.
REQ-023 Masking a channel shall not clear its already-set sticky bit.
REQ-024 FSM states: IDLE, REQ, HALT; reset state IDLE.
REQ-025 IDLE -> REQ on edge with any_active=1 and STOP_EN=1.
REQ-026 REQ -> HALT on edge with stop_ack=1; otherwise remain in REQ.
REQ-027 HALT held until clear; new failures in HALT update sticky_vec/fail_count but do not re-request.
REQ-028 stop_req shall be registered, 1 exactly while in REQ.
REQ-029 stop_ack outside REQ shall be ignored.
REQ-030 STOP_EN=0: FSM stays IDLE, stop_req constant 0; all capture logic unchanged.
REQ-031 clear=1 shall, on that edge, zero sticky_vec, fail_count, first_valid, first_id, and force FSM to IDLE from any state.
REQ-032 clear and any_active on the same edge: clear wins; that cycle's active is discarded; a persisting failure is captured on the next edge.
REQ-033 clear and stop_ack on the same edge in REQ: clear wins, state IDLE.

Reset
REQ-034 rst=1 shall asynchronously force FAILURE=0, sticky_vec=0, first_valid=0, first_id=0, fail_count=0, stop_req=0, state IDLE.
REQ-035 Reset asserted mid-handshake (REQ or HALT) shall drop stop_req immediately without waiting for a clock edge.
REQ-036 First edge after rst deasserts shall sample inputs normally.

Verification
REQ-037 NUM_CH=4, mask=0, fail_in=4'b0100 for 1 cycle -> next edge sticky_vec=4'b0100, first_id=2, first_valid=1, fail_count=1, stop_req=1; FAILURE=1 one cycle later.
REQ-038 fail_in=4'b1010 same cycle from clean state -> first_id=1; later fail_in=4'b0001 -> first_id stays 1, sticky_vec=4'b1011.
REQ-039 CNT_W=2, fail_in held 6 cycles -> fail_count 1,2,3,3,3,3.
REQ-040 In REQ, stop_ack=1 -> stop_req 0 next edge, state HALT; further failures leave stop_req=0; clear -> IDLE, all outputs 0.
REQ-041 mask=4'b0001, fail_in=4'b0001 -> no capture, stop_req=0; clear and fail_in=4'b0010 on same edge -> nothing captured that edge, captured next edge if held.
REQ-042 rst asserted between clock edges while stop_req=1 -> stop_req, FAILURE, sticky_vec 0 immediately; STOP_EN=0 build never asserts stop_req.
